// File: rtl/prescaler.sv
// Programmable rollover prescaler with deferred period reload.
// Emits one roll-over pulse every active_period enabled cycles.
module prescaler #(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned RESET_PERIOD = 1000
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_period,
  output logic             o_roll_over,
  output logic             o_load_ack,
  output logic             o_pending,
  output logic [WIDTH-1:0] o_count
);

  localparam logic [WIDTH-1:0] RST_PER = WIDTH'(RESET_PERIOD);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] act_q, act_d;
  logic [WIDTH-1:0] pper_q, pper_d;
  logic             pend_q, pend_d;
  logic             roll_q, roll_d;
  logic             ack_q, ack_d;

  logic [WIDTH-1:0] term;
  logic             wrap;

  // Periods 0 and 1 both collapse to a terminal of 0.
  always_comb begin
    term = '0;
    if (act_q > ONE) term = act_q - ONE;
  end

  assign wrap = i_enable && (count_q == term);

  // Next state: count, wrap-aligned period swap, pending capture.
  always_comb begin
    count_d = count_q;
    act_d   = act_q;
    pper_d  = pper_q;
    pend_d  = pend_q;
    roll_d  = 1'b0;
    ack_d   = 1'b0;
    if (wrap) begin
      count_d = '0;
      roll_d  = 1'b1;
      if (i_load) begin
        act_d  = i_period;
        pend_d = 1'b0;
        ack_d  = 1'b1;
      end else if (pend_q) begin
        act_d  = pper_q;
        pend_d = 1'b0;
        ack_d  = 1'b1;
      end
    end else begin
      if (i_enable) count_d = count_q + ONE;
      if (i_load) begin
        pper_d = i_period;
        pend_d = 1'b1;
      end
    end
  end

  // State registers; reset overrides any load in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count_q <= '0;
      act_q   <= RST_PER;
      pper_q  <= '0;
      pend_q  <= 1'b0;
      roll_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      act_q   <= act_d;
      pper_q  <= pper_d;
      pend_q  <= pend_d;
      roll_q  <= roll_d;
      ack_q   <= ack_d;
    end
  end

  assign o_roll_over = roll_q;
  assign o_load_ack  = ack_q;
  assign o_pending   = pend_q;
  assign o_count     = count_q;

endmodule

// File: tb/tb_prescaler.sv
// Bench for prescaler: directed scenarios then random traffic,
// all checked against a cycle-level period model.
module tb_prescaler;

  localparam int W  = 8;
  localparam int RP = 4;

  logic         clk = 1'b0;
  logic         rst, en, ld;
  logic [W-1:0] per;
  logic         roll, ack, pend;
  logic [W-1:0] cnt;

  int vectors = 0;
  int miscompares = 0;

  int m_cnt, m_act, m_pval;
  bit m_pend, m_roll, m_ack;

  always #5 clk = ~clk;

  prescaler #(.WIDTH(W), .RESET_PERIOD(RP)) dut (
    .i_clk(clk),
    .i_reset(rst),
    .i_enable(en),
    .i_load(ld),
    .i_period(per),
    .o_roll_over(roll),
    .o_load_ack(ack),
    .o_pending(pend),
    .o_count(cnt)
  );

  task automatic model_step(input bit r, input bit e,
                            input bit l, input int p);
    int  eff;
    bit  w;
    if (r) begin
      m_cnt = 0; m_act = RP; m_pend = 0;
      m_roll = 0; m_ack = 0;
      return;
    end
    eff = (m_act < 2) ? 1 : m_act;
    w = e && (m_cnt + 1 >= eff);
    m_roll = w;
    m_ack = 0;
    if (w) begin
      m_cnt = 0;
      if (l) begin
        m_act = p; m_pend = 0; m_ack = 1;
      end else if (m_pend) begin
        m_act = m_pval; m_pend = 0; m_ack = 1;
      end
    end else begin
      if (e) m_cnt = m_cnt + 1;
      if (l) begin
        m_pval = p; m_pend = 1;
      end
    end
  endtask

  task automatic check(input string tag);
    vectors++;
    assert (cnt === W'(m_cnt) && roll === m_roll &&
            ack === m_ack && pend === m_pend)
    else begin
      miscompares++;
      $error("FAIL %s: got cnt=%0d roll=%b ack=%b pend=%b want cnt=%0d roll=%b ack=%b pend=%b",
             tag, cnt, roll, ack, pend, m_cnt, m_roll, m_ack, m_pend);
    end
  endtask

  task automatic cyc(input bit r, input bit e, input bit l,
                     input int p, input string tag);
    @(negedge clk);
    rst = r; en = e; ld = l; per = W'(p);
    @(posedge clk);
    model_step(r, e, l, p);
    #1;
    check(tag);
  endtask

  initial begin
    rst = 1; en = 0; ld = 0; per = '0;
    m_cnt = 0; m_act = RP; m_pval = 0;
    m_pend = 0; m_roll = 0; m_ack = 0;
    cyc(1, 0, 0, 0, "reset");
    cyc(1, 1, 1, 9, "reset_load");

    // Free run at period 4: 0,1,2,3,0 with pulse per wrap.
    for (int i = 0; i < 9; i++) cyc(0, 1, 0, 0, "run4");

    // Load 6 mid-period; applies at the next wrap.
    while (m_cnt != 1) cyc(0, 1, 0, 0, "align1");
    cyc(0, 1, 1, 6, "load6");
    for (int i = 0; i < 14; i++) cyc(0, 1, 0, 0, "run6");

    // Double load before wrap: last one wins.
    cyc(0, 1, 1, 3, "load3");
    cyc(0, 1, 1, 5, "load5");
    for (int i = 0; i < 14; i++) cyc(0, 1, 0, 0, "run5");

    // Load coincident with wrap bypasses pending.
    while (m_cnt != 4) cyc(0, 1, 0, 0, "align4");
    cyc(0, 1, 1, 4, "wrapload");
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0, "run4b");

    // Period 0 degenerates to a pulse every cycle.
    cyc(0, 1, 1, 0, "load0");
    for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0, "run0");
    assert (cnt === '0 && roll === 1'b1) else begin
      miscompares++;
      $error("FAIL per0: got cnt=%0d roll=%b want cnt=0 roll=1",
             cnt, roll);
    end
    vectors++;

    // Back to 4, freeze at count 2 for 10 cycles.
    cyc(0, 1, 1, 4, "load4");
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, "run4c");
    while (m_cnt != 2) cyc(0, 1, 0, 0, "align2");
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, "hold");
    cyc(0, 0, 1, 7, "holdload");
    for (int i = 0; i < 12; i++) cyc(0, 1, 0, 0, "resume");

    // Reset at count 3 with a load: load discarded.
    while (m_cnt != 3) cyc(0, 1, 0, 0, "align3");
    cyc(1, 1, 1, 9, "rstmid");
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0, "postrst");

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit r, e, l;
      int p;
      r = ($urandom_range(0, 199) == 0);
      e = ($urandom_range(0, 9) != 0);
      l = ($urandom_range(0, 11) == 0);
      p = $urandom_range(0, 9);
      if ($urandom_range(0, 49) == 0) p = $urandom_range(0, 255);
      cyc(r, e, l, p, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/prescaler.md
PRESCALER -- requirements
Module: prescaler

Purpose: generates the single-cycle rollover pulse that drives the downstream toggle clock stage; one pulse every PERIOD enabled cycles of i_clk.

Interface
REQ-001 Parameter WIDTH, default 16, bit width of counter and period values.
REQ-002 Parameter RESET_PERIOD, default 1000, active period loaded on reset.
REQ-003 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 i_reset  input  1  synchronous, active-high reset, sampled on rising edge of i_clk.
REQ-005 i_enable  input  1  high: counter advances each cycle; low: counter frozen.
REQ-006 i_load  input  1  one-cycle strobe; samples i_period as the pending period.
REQ-007 i_period  input  WIDTH  requested period in i_clk cycles, unsigned.
REQ-008 o_roll_over  output  1  registered one-cycle pulse at each period wrap.
REQ-009 o_load_ack  output  1  registered one-cycle pulse when a pending period becomes active.
REQ-010 o_pending  output  1  high while a loaded period awaits application.
REQ-011 o_count  output  WIDTH  current counter value, 0..active_period-1.

Function
REQ-012 Internal registers SHALL be: count, active_period, pending_period, pending flag, o_roll_over, o_load_ack.
REQ-013 Effective terminal value SHALL be active_period-1; active_period of 0 or 1 SHALL be treated as 1 (wrap every enabled cycle).
REQ-014 With i_enable high and count != terminal, count SHALL increment by 1 per cycle; o_roll_over SHALL be 0 next cycle.
REQ-015 With i_enable high and count == terminal (wrap cycle), count SHALL become 0 and o_roll_over SHALL be 1 in the following cycle only.
REQ-016 Latency: o_roll_over SHALL assert exactly one cycle after the cycle in which count equals terminal; pulse spacing SHALL equal active_period enabled cycles.
REQ-017 With i_enable low, count, active_period SHALL hold; o_roll_over and o_load_ack SHALL be 0.
REQ-018 i_load high SHALL capture i_period into pending_period and set pending, in any state including i_enable low.
REQ-019 i_load while pending already set SHALL overwrite pending_period (last write wins); no ack for the overwritten value.
REQ-020 Pending period SHALL be applied only at a wrap cycle: active_period <= pending_period, pending cleared, o_load_ack pulses together with o_roll_over.
REQ-021 i_load coincident with a wrap cycle SHALL apply the i_period value presented that cycle directly (bypasses pending_period), pending cleared, o_load_ack pulses.
REQ-022 Period changes SHALL never truncate or extend the period in progress; no count value >= active_period SHALL ever occur.
REQ-023 All arithmetic SHALL be WIDTH-bit unsigned; count SHALL never wrap through 2^WIDTH.
REQ-024 o_pending SHALL equal the pending flag register.

Reset
REQ-025 i_reset high SHALL, at the next rising edge, set count=0, active_period=RESET_PERIOD, pending=0, o_roll_over=0, o_load_ack=0, regardless of i_enable/i_load.
REQ-026 i_reset SHALL take priority over i_load; a load in a reset cycle SHALL be discarded.
REQ-027 Reset mid-period SHALL restart counting from 0; first o_roll_over after release SHALL occur active_period enabled cycles later, plus 1 latency cycle.

Verification
REQ-028 WIDTH=8, RESET_PERIOD=4, i_enable held high after reset -> o_roll_over pulses every 4th cycle, o_count sequence 0,1,2,3,0.
REQ-029 Period 4 running; i_load with i_period=6 when count=1 -> o_pending=1, current period completes at 4, o_roll_over and o_load_ack pulse together, next pulse 6 cycles later, o_pending=0.
REQ-030 i_load i_period=3 then i_period=5 before wrap -> only 5 applied, single o_load_ack.
REQ-031 i_period=0 loaded and applied -> o_roll_over high every cycle, o_count stays 0.
REQ-032 i_enable low for 10 cycles at count=2 -> o_count holds 2, no pulses; resumes wrap 2 enabled cycles after re-enable (period 4).
REQ-033 i_reset asserted at count=3 with i_load high -> count=0, pending=0, no o_roll_over, active_period=RESET_PERIOD.
